// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: default line
// settings, the receiver state encoding and the bit-period helper.
package serial_pkg;

  localparam int DEFAULT_CLK_FREQ  = 100_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  // System clocks per serial bit (integer division, rounds down).
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/recv_serial_if.sv
// Consumer-side bundle of the UART receiver: holding buffer, read strobe,
// sticky error flags and busy.
//
// Handshake: data_out is meaningful while valid=1. A cycle with valid=1 and
// re=1 consumes the byte and valid falls on the next clock unless a new byte
// lands in that same cycle. re while valid=0 has no effect. The receiver never
// stalls: a new byte always overwrites the buffer, flagging overrun when the
// previous byte was still unread.
interface recv_serial_if;
  logic [7:0] data_out;
  logic       valid;
  logic       re;
  logic       clr_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output data_out, valid, frame_err, overrun, busy,
    input  re, clr_err
  );

  modport slave (
    input  data_out, valid, frame_err, overrun, busy,
    output re, clr_err
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic neg_rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: the input moves one stage per clock.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronising flop pair with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!neg_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/recv_serial.sv
// 8N1 UART receiver. Samples each bit at mid-period, checks start/stop bits,
// shifts data LSB-first and presents bytes through a one-entry buffer.
// CLKS_PER_BIT must be at least 4 for the mid-bit counting to make sense.
module recv_serial
  import serial_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic             clk,
  input  logic             neg_rst,
  input  logic             data_in,
  recv_serial_if.master    bus,
  output rx_state_t        dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic rx_s;

  rx_state_t        state_q,     state_d;
  logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_out_q,  data_out_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  // Line synchroniser; resets low so a reset always lands in WAIT_IDLE
  // until the line is seen high.
  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk     (clk),
    .neg_rst (neg_rst),
    .d       (data_in),
    .q       (rx_s)
  );

  // Next-state logic: receiver FSM, holding buffer handshake, sticky flags.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    // Consumer read and error clear come first so a load or a new error
    // in the same cycle takes priority.
    if (valid_q && bus.re) valid_d = 1'b0;
    if (bus.clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    unique case (state_q)
      WAIT_IDLE: begin
        // Hold off until the line is idle so we never lock onto a
        // mid-frame bit or a break.
        if (rx_s) state_d = IDLE;
      end
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            if (valid_q && !bus.re) overrun_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!neg_rst) begin
      state_q     <= WAIT_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_out_q  <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_recv_serial.sv
// Directed bench for recv_serial at 16 clocks per bit.
module tb_recv_serial;
  import serial_pkg::*;

  logic      clk;
  logic      neg_rst;
  logic      data_in;
  rx_state_t dbg_state;
  int        total;
  int        fails;

  recv_serial_if bus ();

  recv_serial #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk       (clk),
    .neg_rst   (neg_rst),
    .data_in   (data_in),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock: posedges at 5,15,...; inputs driven and outputs sampled on negedges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    neg_rst = 1'b0;
    data_in = 1'b1;
    bus.re = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    neg_rst = 1'b1;
    tick(4);
  endtask

  // One 160-clock frame; the line is left at the stop-bit level. re is
  // pulsed high for exactly frame cycle re_at (-1 for never).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int re_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 160; c++) begin
      data_in = bits[c / 16];
      bus.re  = (c == re_at);
      tick(1);
    end
    bus.re = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 10) begin
      tick(1);
      n++;
    end
    check(tag, 8'(bus.busy), 8'h00);
  endtask

  initial begin
    total = 0;
    fails = 0;
    neg_rst = 1'b0;
    data_in = 1'b1;
    bus.re = 1'b0;
    bus.clr_err = 1'b0;

    // Reset values
    tick(3);
    check("rst_valid", 8'(bus.valid), 8'h00);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_ferr", 8'(bus.frame_err), 8'h00);
    check("rst_ovr", 8'(bus.overrun), 8'h00);
    check("rst_busy", 8'(bus.busy), 8'h01);
    check("rst_state", 8'(dbg_state), 8'(WAIT_IDLE));
    neg_rst = 1'b1;
    tick(4);
    check("idle_busy", 8'(bus.busy), 8'h00);

    // Single byte then read
    send_frame(8'h48, 1'b1, -1);
    tick(2);
    check("s1_valid", 8'(bus.valid), 8'h01);
    check("s1_data", bus.data_out, 8'h48);
    check("s1_ferr", 8'(bus.frame_err), 8'h00);
    check("s1_ovr", 8'(bus.overrun), 8'h00);
    check("s1_busy", 8'(bus.busy), 8'h00);
    bus.re = 1'b1;
    tick(1);
    bus.re = 1'b0;
    check("s1_read_valid", 8'(bus.valid), 8'h00);
    check("s1_read_data", bus.data_out, 8'h48);

    // Back-to-back without read -> overrun
    do_reset();
    send_frame(8'h48, 1'b1, -1);
    tick(2);
    check("b2b_first_ovr", 8'(bus.overrun), 8'h00);
    send_frame(8'h65, 1'b1, -1);
    tick(2);
    check("b2b_data", bus.data_out, 8'h65);
    check("b2b_valid", 8'(bus.valid), 8'h01);
    check("b2b_ovr", 8'(bus.overrun), 8'h01);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("b2b_clr_ovr", 8'(bus.overrun), 8'h00);
    check("b2b_clr_valid", 8'(bus.valid), 8'h01);

    // Framing error, line held low afterwards
    do_reset();
    send_frame(8'h55, 1'b0, -1);
    tick(40);
    check("fe_ferr", 8'(bus.frame_err), 8'h01);
    check("fe_valid", 8'(bus.valid), 8'h00);
    check("fe_data", bus.data_out, 8'h00);
    check("fe_busy", 8'(bus.busy), 8'h01);
    data_in = 1'b1;
    wait_not_busy("fe_release_busy");
    send_frame(8'hA5, 1'b1, -1);
    tick(2);
    check("fe_next_valid", 8'(bus.valid), 8'h01);
    check("fe_next_data", bus.data_out, 8'hA5);
    check("fe_sticky", 8'(bus.frame_err), 8'h01);

    // Glitch on an idle line
    do_reset();
    data_in = 1'b0;
    tick(4);
    check("gl_busy_start", 8'(bus.busy), 8'h01);
    data_in = 1'b1;
    tick(20);
    check("gl_busy", 8'(bus.busy), 8'h00);
    check("gl_valid", 8'(bus.valid), 8'h00);
    check("gl_ferr", 8'(bus.frame_err), 8'h00);
    check("gl_ovr", 8'(bus.overrun), 8'h00);

    // Reset during data bit 3 of 0x3C, line low at release
    do_reset();
    data_in = 1'b0;
    tick(16);
    data_in = 1'b0;
    tick(16);
    data_in = 1'b0;
    tick(16);
    data_in = 1'b1;
    tick(16);
    tick(8);
    neg_rst = 1'b0;
    tick(2);
    data_in = 1'b0;
    neg_rst = 1'b1;
    tick(20);
    check("mr_valid", 8'(bus.valid), 8'h00);
    check("mr_data", bus.data_out, 8'h00);
    check("mr_ferr", 8'(bus.frame_err), 8'h00);
    check("mr_ovr", 8'(bus.overrun), 8'h00);
    check("mr_busy", 8'(bus.busy), 8'h01);
    data_in = 1'b1;
    wait_not_busy("mr_release_busy");
    send_frame(8'h0A, 1'b1, -1);
    tick(2);
    check("mr_next_valid", 8'(bus.valid), 8'h01);
    check("mr_next_data", bus.data_out, 8'h0A);

    // re on the same clock as the stop-bit load (posedge 154.5 of the frame)
    do_reset();
    send_frame(8'h65, 1'b1, -1);
    tick(2);
    check("co_first_valid", 8'(bus.valid), 8'h01);
    send_frame(8'h6C, 1'b1, 154);
    tick(2);
    check("co_valid", 8'(bus.valid), 8'h01);
    check("co_data", bus.data_out, 8'h6C);
    check("co_ovr", 8'(bus.overrun), 8'h00);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
